sudoku_game_ctrl: RTL

Parametrised single-clock successor to the sudoku main game FSM. Latches a real 2-bit difficulty selection and drives a configurable-width hint mask. Adds three behaviours the current controller lacks: a datapath check handshake with timeout, a limited-attempt counter with a LOST end state, and enter edge detection. Sits between the board/keypad front end and the check datapath.

---
 rtl/sudoku_pkg.sv | 29 ++
 rtl/sudoku_chk_timer.sv | 26 ++
 rtl/sudoku_game_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared encodings for the sudoku game controller: state codes, difficulty
// codes and the attempt-counter width helper.
package sudoku_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    EMPTY      = 4'd1,
    SET_DIFF   = 4'd2,
    LOAD_HINTS = 4'd3,
    REG_INP    = 4'd4,
    CHECK      = 4'd5,
    WRONG      = 4'd6,
    FIN        = 4'd7,
    LOST       = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    DIFF_NONE = 2'b00,
    DIFF_EASY = 2'b01,
    DIFF_MED  = 2'b10,
    DIFF_HARD = 2'b11
  } diff_t;

  // Width needed to hold 0..max_tries; an unlimited build still gets one bit.
  function automatic int try_w(input int max_tries);
    return (max_tries < 1) ? 1 : $clog2(max_tries + 1);
  endfunction

endpackage

// File: rtl/sudoku_chk_timer.sv
// CHECK-state watchdog: counts CHECK cycles and flags the last allowed one.
module sudoku_chk_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clka,
  input  logic restart,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clka) begin
    if (restart || clr)
      r_cnt <= '0;
    else if (en && (r_cnt != CW'(TIMEOUT)))
      r_cnt <= r_cnt + 1'b1;
  end

  // Counter holds k-1 during the k-th CHECK cycle, so this fires on cycle TIMEOUT.
  assign expired = en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku main game controller: difficulty latch, hint mask, check handshake
// with timeout, limited attempts and enter edge detection.
module sudoku_game_ctrl
  import sudoku_pkg::*;
#(
  parameter  int                HINT_W        = 8,
  parameter  logic [HINT_W-1:0] EASY_MASK     = HINT_W'('h0F),
  parameter  logic [HINT_W-1:0] MED_MASK      = HINT_W'('h07),
  parameter  logic [HINT_W-1:0] HARD_MASK     = HINT_W'('h03),
  parameter  int                MAX_TRIES     = 3,
  parameter  int                CHECK_TIMEOUT = 16,
  localparam int                TRY_W         = try_w(MAX_TRIES)
) (
  input  logic              clka,
  input  logic              restart,
  input  logic              enter,
  input  logic [1:0]        difficulty,
  input  logic              check_done,
  input  logic              solved,
  output logic              register_inp_flag,
  output logic              try_again_flag,
  output logic              dp_check,
  output logic              ridx_a,
  output logic              ridx_b,
  output logic [HINT_W-1:0] fill_flag,
  output logic              won,
  output logic              lost,
  output logic [TRY_W-1:0]  tries_left,
  output logic [1:0]        diff_q,
  output logic [3:0]        state
);

  state_t            r_state;
  state_t            w_nxt;
  logic              r_enter_q;
  logic              w_rise;
  logic              w_expired;
  logic              w_fail;
  logic [1:0]        w_diff_nxt;
  logic [TRY_W-1:0]  w_tries_nxt;
  logic [TRY_W-1:0]  w_tries_dec;
  logic [HINT_W-1:0] w_mask;

  assign w_rise      = enter & ~r_enter_q;
  assign w_tries_dec = (tries_left == '0) ? '0 : tries_left - 1'b1;
  assign state       = r_state;

  sudoku_chk_timer #(.TIMEOUT(CHECK_TIMEOUT)) u_timer (
    .clka    (clka),
    .restart (restart),
    .clr     (r_state != CHECK),
    .en      (r_state == CHECK),
    .expired (w_expired)
  );

  always_comb begin
    w_nxt       = r_state;
    w_diff_nxt  = diff_q;
    w_tries_nxt = tries_left;
    w_fail      = 1'b0;
    case (r_state)
      IDLE:       w_nxt = EMPTY;
      EMPTY:      w_nxt = SET_DIFF;
      SET_DIFF:
        if (w_rise && (difficulty != DIFF_NONE)) begin
          w_diff_nxt  = difficulty;
          w_tries_nxt = TRY_W'(MAX_TRIES);
          w_nxt       = LOAD_HINTS;
        end
      LOAD_HINTS: w_nxt = REG_INP;
      REG_INP:    if (w_rise) w_nxt = CHECK;
      CHECK:
        // A result arriving on the timeout cycle takes precedence over the timeout.
        if (check_done) begin
          if (solved) w_nxt = FIN;
          else        w_fail = 1'b1;
        end else if (w_expired) begin
          w_fail = 1'b1;
        end
      WRONG:      if (w_rise) w_nxt = REG_INP;
      FIN:        w_nxt = FIN;
      LOST:       w_nxt = LOST;
      default:    w_nxt = IDLE;
    endcase
    if (w_fail) begin
      if (MAX_TRIES != 0) begin
        w_tries_nxt = w_tries_dec;
        w_nxt       = (w_tries_dec == '0) ? LOST : WRONG;
      end else begin
        w_nxt = WRONG;
      end
    end
    case (w_diff_nxt)
      DIFF_EASY: w_mask = EASY_MASK;
      DIFF_MED:  w_mask = MED_MASK;
      DIFF_HARD: w_mask = HARD_MASK;
      default:   w_mask = '0;
    endcase
  end

  // Outputs are Moore decodes of the next state, so they line up with r_state.
  always_ff @(posedge clka) begin
    if (restart) begin
      r_state           <= IDLE;
      r_enter_q         <= 1'b1;
      diff_q            <= DIFF_NONE;
      tries_left        <= TRY_W'(MAX_TRIES);
      register_inp_flag <= 1'b0;
      try_again_flag    <= 1'b0;
      dp_check          <= 1'b0;
      ridx_a            <= 1'b0;
      ridx_b            <= 1'b0;
      fill_flag         <= '0;
      won               <= 1'b0;
      lost              <= 1'b0;
    end else begin
      r_state           <= w_nxt;
      r_enter_q         <= enter;
      diff_q            <= w_diff_nxt;
      tries_left        <= w_tries_nxt;
      register_inp_flag <= (w_nxt == REG_INP);
      try_again_flag    <= (w_nxt == WRONG);
      dp_check          <= (w_nxt == CHECK) && (r_state != CHECK);
      ridx_a            <= (w_nxt == SET_DIFF);
      ridx_b            <= (w_nxt == SET_DIFF);
      fill_flag         <= (w_nxt == LOAD_HINTS) ? w_mask : '0;
      won               <= (w_nxt == FIN);
      lost              <= (w_nxt == LOST);
    end
  end

endmodule
